// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter that shares the two CDB result lanes
// among the result producers (ALU reservation stations, load/store path,
// branch unit). It grants up to two valid results per cycle and registers
// them onto lane 1 and lane 2. It also returns a same-cycle ready to each
// granted producer.
//
// Handshake: a producer raises req_valid[i] with a non-zero req_ROBEN and
// holds valid, tag and value stable until it sees req_ready[i] high in the
// same cycle. A transfer happens in exactly the cycles where valid && ready.
// req_ready is combinational from req_valid, req_ROBEN, ROB_FLUSH_Flag, rst
// and rr_ptr, never from req_VAL. The accepted result is visible on the
// CDB lanes for exactly one cycle, starting at the following rising edge.
module cdb_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ROBEN_W = 5,
  parameter int DATA_W  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ROB_FLUSH_Flag,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*ROBEN_W-1:0]   req_ROBEN,
  input  logic [N_REQ*DATA_W-1:0]    req_VAL,
  output logic [N_REQ-1:0]           req_ready,
  output logic [ROBEN_W-1:0]         CDB_ROBEN1,
  output logic [ROBEN_W-1:0]         CDB_ROBEN2,
  output logic [DATA_W-1:0]          CDB_ROBEN1_VAL,
  output logic [DATA_W-1:0]          CDB_ROBEN2_VAL,
  output logic [$clog2(N_REQ)-1:0]   rr_ptr
);

  localparam int PTR_W = $clog2(N_REQ);

  // Round-robin pointer: the producer searched first in the current cycle.
  // This is the only arbitration state, and it is exported on rr_ptr.
  logic [PTR_W-1:0]   r_rr_ptr;

  // Registered CDB lanes. A tag of 0 marks an idle lane, and its value is
  // then forced to 0.
  logic [ROBEN_W-1:0] r_l1_tag;
  logic [DATA_W-1:0]  r_l1_val;
  logic [ROBEN_W-1:0] r_l2_tag;
  logic [DATA_W-1:0]  r_l2_val;

  // Unpacked per-producer views of the flat request buses.
  logic [ROBEN_W-1:0] w_tag [N_REQ];
  logic [DATA_W-1:0]  w_val [N_REQ];
  logic [N_REQ-1:0]   w_eligible;

  // Producer index visited at search step k, starting from r_rr_ptr.
  logic [PTR_W:0]     w_sum     [N_REQ];
  logic [PTR_W-1:0]   w_rot_idx [N_REQ];

  // Grant A (first eligible) and grant B (second eligible) in search order.
  logic               w_found_a;
  logic               w_found_b;
  logic [PTR_W-1:0]   w_idx_a;
  logic [PTR_W-1:0]   w_idx_b;

  // Pointer that follows the last grant of this cycle.
  logic [PTR_W-1:0]   w_last_idx;
  logic [PTR_W-1:0]   w_next_ptr;

  // Values loaded into the lanes at the next edge.
  logic [ROBEN_W-1:0] w_l1_tag;
  logic [DATA_W-1:0]  w_l1_val;
  logic [ROBEN_W-1:0] w_l2_tag;
  logic [DATA_W-1:0]  w_l2_val;

  logic [N_REQ-1:0]   w_ready;

  // Slice the flat buses and qualify each producer. A tag of 0 never
  // competes. Flush and reset mask every producer, so neither grants nor
  // pointer moves can happen in those cycles.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign w_tag[gi]      = req_ROBEN[gi*ROBEN_W +: ROBEN_W];
    assign w_val[gi]      = req_VAL[gi*DATA_W +: DATA_W];
    assign w_eligible[gi] = req_valid[gi] && (w_tag[gi] != '0)
                            && !ROB_FLUSH_Flag && !rst;
  end

  // Circular search order: r_rr_ptr + k, wrapped modulo N_REQ. The sum is
  // one bit wider than the pointer, so the wrap compare works for any
  // N_REQ, including values that are not powers of two.
  for (genvar gk = 0; gk < N_REQ; gk++) begin : g_order
    assign w_sum[gk]     = {1'b0, r_rr_ptr} + (PTR_W+1)'(gk);
    assign w_rot_idx[gk] = (w_sum[gk] >= (PTR_W+1)'(N_REQ))
                           ? PTR_W'(w_sum[gk] - (PTR_W+1)'(N_REQ))
                           : PTR_W'(w_sum[gk]);
  end

  // Walk the search order once. The first eligible producer becomes grant
  // A and the second becomes grant B. Later eligible producers wait.
  always_comb begin
    w_found_a = 1'b0;
    w_found_b = 1'b0;
    w_idx_a   = '0;
    w_idx_b   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (w_eligible[w_rot_idx[k]]) begin
        if (!w_found_a) begin
          w_found_a = 1'b1;
          w_idx_a   = w_rot_idx[k];
        end else if (!w_found_b) begin
          w_found_b = 1'b1;
          w_idx_b   = w_rot_idx[k];
        end
      end
    end
  end

  // Ready goes only to the producers that won a lane this cycle.
  always_comb begin
    w_ready = '0;
    if (w_found_a) w_ready[w_idx_a] = 1'b1;
    if (w_found_b) w_ready[w_idx_b] = 1'b1;
  end

  // The next search starts just past the last producer served. This keeps
  // a continuously eligible producer within ceil(N_REQ/2) cycles of a grant.
  always_comb begin
    w_last_idx = w_found_b ? w_idx_b : w_idx_a;
    if (w_last_idx == PTR_W'(N_REQ - 1)) begin
      w_next_ptr = '0;
    end else begin
      w_next_ptr = PTR_W'(w_last_idx + 1'b1);
    end
  end

  // Lane steering: grant A always lands on lane 1, so lane 2 is busy only
  // when lane 1 is. A missing grant loads an all-zero lane.
  always_comb begin
    w_l1_tag = '0;
    w_l1_val = '0;
    w_l2_tag = '0;
    w_l2_val = '0;
    if (w_found_a) begin
      w_l1_tag = w_tag[w_idx_a];
      w_l1_val = w_val[w_idx_a];
    end
    if (w_found_b) begin
      w_l2_tag = w_tag[w_idx_b];
      w_l2_val = w_val[w_idx_b];
    end
  end

  // Lane and pointer registers. Reset clears everything and drops any
  // grant made in the reset cycle. A flush cycle has no grants, so the
  // lanes load zeros and the pointer holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= '0;
      r_l1_tag <= '0;
      r_l1_val <= '0;
      r_l2_tag <= '0;
      r_l2_val <= '0;
    end else begin
      r_l1_tag <= w_l1_tag;
      r_l1_val <= w_l1_val;
      r_l2_tag <= w_l2_tag;
      r_l2_val <= w_l2_val;
      if (w_found_a) begin
        r_rr_ptr <= w_next_ptr;
      end
    end
  end

  assign req_ready      = w_ready;
  assign CDB_ROBEN1     = r_l1_tag;
  assign CDB_ROBEN1_VAL = r_l1_val;
  assign CDB_ROBEN2     = r_l2_tag;
  assign CDB_ROBEN2_VAL = r_l2_val;
  assign rr_ptr         = r_rr_ptr;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed vector table, a short hand-built flush sequence,
// and a randomized soak checked against a queue-based round-robin model.
module tb_cdb_arbiter;

  localparam int N  = 4;
  localparam int RW = 5;
  localparam int DW = 32;
  localparam int PW = $clog2(N);

  // ---------------- clock / reset / DUT ----------------
  logic            clk;
  logic            rst;
  logic            ROB_FLUSH_Flag;
  logic [N-1:0]    req_valid;
  logic [N*RW-1:0] req_ROBEN;
  logic [N*DW-1:0] req_VAL;
  logic [N-1:0]    req_ready;
  logic [RW-1:0]   CDB_ROBEN1;
  logic [RW-1:0]   CDB_ROBEN2;
  logic [DW-1:0]   CDB_ROBEN1_VAL;
  logic [DW-1:0]   CDB_ROBEN2_VAL;
  logic [PW-1:0]   rr_ptr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  cdb_arbiter #(.N_REQ(N), .ROBEN_W(RW), .DATA_W(DW)) dut (
    .clk            (clk),
    .rst            (rst),
    .ROB_FLUSH_Flag (ROB_FLUSH_Flag),
    .req_valid      (req_valid),
    .req_ROBEN      (req_ROBEN),
    .req_VAL        (req_VAL),
    .req_ready      (req_ready),
    .CDB_ROBEN1     (CDB_ROBEN1),
    .CDB_ROBEN2     (CDB_ROBEN2),
    .CDB_ROBEN1_VAL (CDB_ROBEN1_VAL),
    .CDB_ROBEN2_VAL (CDB_ROBEN2_VAL),
    .rr_ptr         (rr_ptr)
  );

  // ---------------- checking helpers ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic            rst;
    logic            flush;
    logic [N-1:0]    valid;
    logic [N*RW-1:0] tags;
    logic [N*DW-1:0] vals;
    logic [N-1:0]    exp_ready;
    int              ea;    // producer expected on lane 1, -1 if none
    int              eb;    // producer expected on lane 2, -1 if none
    int              eptr;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [DW-1:0] val_of(input int i, input int t);
    return 32'h5A00_0000 | DW'(i << 16) | DW'(t);
  endfunction

  function automatic vec_t mk_row(input logic r, input logic f, input logic [N-1:0] v,
                                  input int t0, input int t1, input int t2, input int t3,
                                  input logic [N-1:0] er, input int a, input int b, input int p);
    vec_t x;
    int   t[N];
    t[0] = t0; t[1] = t1; t[2] = t2; t[3] = t3;
    x.rst = r; x.flush = f; x.valid = v;
    for (int i = 0; i < N; i++) begin
      x.tags[i*RW +: RW] = RW'(t[i]);
      x.vals[i*DW +: DW] = val_of(i, t[i]);
    end
    x.exp_ready = er; x.ea = a; x.eb = b; x.eptr = p;
    return x;
  endfunction

  // Driver task: applies one row, checks ready mid-cycle and the registered
  // lanes and pointer just after the following edge.
  task automatic run_row(input string tag, input vec_t v);
    logic [RW-1:0] et1, et2;
    logic [DW-1:0] ev1, ev2;
    int ia, ib;
    ia = (v.ea < 0) ? 0 : v.ea;
    ib = (v.eb < 0) ? 0 : v.eb;
    et1 = (v.ea < 0) ? '0 : v.tags[ia*RW +: RW];
    ev1 = (v.ea < 0) ? '0 : v.vals[ia*DW +: DW];
    et2 = (v.eb < 0) ? '0 : v.tags[ib*RW +: RW];
    ev2 = (v.eb < 0) ? '0 : v.vals[ib*DW +: DW];
    rst = v.rst; ROB_FLUSH_Flag = v.flush;
    req_valid = v.valid; req_ROBEN = v.tags; req_VAL = v.vals;
    @(negedge clk);
    check({tag, " ready"}, 64'(req_ready), 64'(v.exp_ready));
    @(posedge clk); #1;
    check({tag, " lane1 tag"}, 64'(CDB_ROBEN1), 64'(et1));
    check({tag, " lane1 val"}, 64'(CDB_ROBEN1_VAL), 64'(ev1));
    check({tag, " lane2 tag"}, 64'(CDB_ROBEN2), 64'(et2));
    check({tag, " lane2 val"}, 64'(CDB_ROBEN2_VAL), 64'(ev2));
    check({tag, " rr_ptr"}, 64'(rr_ptr), 64'(v.eptr));
  endtask

  // ---------------- reference model ----------------
  // Lists the eligible producers in circular order from ptr; the first two
  // in that list are the grants.
  function automatic logic [N-1:0] model_grant(input logic [N-1:0] v, input logic [RW-1:0] t [N],
                                               input bit r, input bit f, input int ptr,
                                               output int ga, output int gb);
    int order[$];
    logic [N-1:0] rdy;
    rdy = '0; ga = -1; gb = -1;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (ptr + k) % N;
      if (v[i] && t[i] != 0 && !r && !f) order.push_back(i);
    end
    if (order.size() > 0) begin ga = order[0]; rdy[ga] = 1'b1; end
    if (order.size() > 1) begin gb = order[1]; rdy[gb] = 1'b1; end
    return rdy;
  endfunction

  // ---------------- scoreboard ----------------
  logic [RW+DW-1:0] exp_q[$];

  // ---------------- stimulus ----------------
  logic [N-1:0]     p_valid;
  logic [RW-1:0]    p_tag [N];
  logic [DW-1:0]    p_val [N];
  int               wait_cnt [N];
  int               m_ptr;
  logic [RW+DW-1:0] m_l1, m_l2;
  logic [N-1:0]     m_ready;
  bit               r, f;
  int               ga, gb;
  vec_t             row;

  initial begin
    rst = 1'b1; ROB_FLUSH_Flag = 1'b0;
    req_valid = '0; req_ROBEN = '0; req_VAL = '0;
    @(posedge clk); #1;

    // Directed table (rows run back to back; pointer carries across rows).
    vecs.push_back(mk_row(1, 0, 4'b1111, 1, 2, 3, 4, 4'b0000, -1, -1, 0)); // reset held
    vecs.push_back(mk_row(1, 0, 4'b1111, 1, 2, 3, 4, 4'b0000, -1, -1, 0));
    vecs.push_back(mk_row(0, 0, 4'b1111, 1, 2, 3, 4, 4'b0011,  0,  1, 2)); // first after release
    row = mk_row(0, 0, 4'b0100, 0, 0, 7, 0, 4'b0100, 2, -1, 3);           // single producer
    row.vals[2*DW +: DW] = 32'hDEAD_BEEF;
    vecs.push_back(row);
    vecs.push_back(mk_row(0, 0, 4'b0000, 0, 0, 0, 0, 4'b0000, -1, -1, 3)); // lanes clear
    vecs.push_back(mk_row(0, 0, 4'b1111, 1, 2, 3, 4, 4'b1001,  3,  0, 1)); // wrap 3 then 0
    vecs.push_back(mk_row(0, 0, 4'b1111, 1, 2, 3, 4, 4'b0110,  1,  2, 3));
    vecs.push_back(mk_row(0, 0, 4'b0011, 0, 9, 0, 0, 4'b0010,  1, -1, 2)); // tag zero skipped
    vecs.push_back(mk_row(0, 0, 4'b0001, 5, 0, 0, 0, 4'b0001,  0, -1, 1));
    vecs.push_back(mk_row(0, 1, 4'b1111, 1, 2, 3, 4, 4'b0000, -1, -1, 1)); // flush
    vecs.push_back(mk_row(0, 0, 4'b1111, 1, 2, 3, 4, 4'b0110,  1,  2, 3));
    vecs.push_back(mk_row(1, 1, 4'b1111, 1, 2, 3, 4, 4'b0000, -1, -1, 0)); // reset beats flush
    vecs.push_back(mk_row(0, 0, 4'b1100, 0, 0, 3, 4, 4'b1100,  2,  3, 0)); // last grant 3 wraps
    vecs.push_back(mk_row(0, 0, 4'b1000, 0, 0, 0, 4, 4'b1000,  3, -1, 0));
    vecs.push_back(mk_row(0, 0, 4'b0000, 0, 0, 0, 0, 4'b0000, -1, -1, 0));
    for (int n = 0; n < vecs.size(); n++) run_row($sformatf("row%0d", n), vecs[n]);

    // Hand-written: two back-to-back flushes must clear a busy lane pair and
    // hold the pointer, and grants resume from the held pointer.
    run_row("seq grant", mk_row(0, 0, 4'b1111, 1, 2, 3, 4, 4'b0011,  0,  1, 2));
    run_row("seq flush1", mk_row(0, 1, 4'b1111, 1, 2, 3, 4, 4'b0000, -1, -1, 2));
    run_row("seq flush2", mk_row(0, 1, 4'b1111, 1, 2, 3, 4, 4'b0000, -1, -1, 2));
    run_row("seq resume", mk_row(0, 0, 4'b1111, 1, 2, 3, 4, 4'b1100,  2,  3, 0));

    // Random soak against the model.
    p_valid = '0; m_ptr = 0; m_l1 = '0; m_l2 = '0;
    for (int i = 0; i < N; i++) begin p_tag[i] = '0; p_val[i] = '0; wait_cnt[i] = 0; end
    for (int cyc = 0; cyc < 10000; cyc++) begin
      r = (cyc == 0) || ($urandom_range(0, 399) == 0);
      f = !r && ($urandom_range(0, 15) == 0);
      for (int i = 0; i < N; i++) begin
        if (!p_valid[i] && $urandom_range(0, 1) == 1) begin
          p_valid[i] = 1'b1;
          p_tag[i]   = ($urandom_range(0, 9) == 0) ? '0 : RW'($urandom_range(1, 31));
          p_val[i]   = $urandom;
        end
        req_ROBEN[i*RW +: RW] = p_tag[i];
        req_VAL[i*DW +: DW]   = p_val[i];
      end
      rst = r; ROB_FLUSH_Flag = f; req_valid = p_valid;
      m_ready = model_grant(p_valid, p_tag, r, f, m_ptr, ga, gb);

      @(negedge clk);
      check("rand ready", 64'(req_ready), 64'(m_ready));
      for (int i = 0; i < N; i++) begin
        if (r) wait_cnt[i] = 0;
        else if (p_valid[i] && p_tag[i] != 0 && !f) begin
          if (req_ready[i]) wait_cnt[i] = 0;
          else begin
            wait_cnt[i]++;
            n_checks++;
            if (wait_cnt[i] > 1) begin
              n_fail++;
              $display("FAIL fairness p%0d: waited %0d cycles, allowed 2", i, wait_cnt[i] + 1);
            end
          end
        end
      end

      @(posedge clk); #1;
      if (r) begin
        m_l1 = '0; m_l2 = '0; m_ptr = 0;
      end else begin
        m_l1 = '0; m_l2 = '0;
        if (ga >= 0) begin m_l1 = {p_tag[ga], p_val[ga]}; exp_q.push_back(m_l1); m_ptr = (ga + 1) % N; end
        if (gb >= 0) begin m_l2 = {p_tag[gb], p_val[gb]}; exp_q.push_back(m_l2); m_ptr = (gb + 1) % N; end
      end
      check("rand lane1", 64'({CDB_ROBEN1, CDB_ROBEN1_VAL}), 64'(m_l1));
      check("rand lane2", 64'({CDB_ROBEN2, CDB_ROBEN2_VAL}), 64'(m_l2));
      check("rand rr_ptr", 64'(rr_ptr), 64'(m_ptr));
      if (CDB_ROBEN1 != 0) begin
        if (exp_q.size() == 0) check("sb lane1 unexpected", 64'(CDB_ROBEN1), 64'(0));
        else check("sb lane1", 64'({CDB_ROBEN1, CDB_ROBEN1_VAL}), 64'(exp_q.pop_front()));
      end
      if (CDB_ROBEN2 != 0) begin
        if (exp_q.size() == 0) check("sb lane2 unexpected", 64'(CDB_ROBEN2), 64'(0));
        else check("sb lane2", 64'({CDB_ROBEN2, CDB_ROBEN2_VAL}), 64'(exp_q.pop_front()));
      end

      for (int i = 0; i < N; i++) begin
        if (i == ga || i == gb || p_tag[i] == 0) p_valid[i] = 1'b0;
        if (!p_valid[i]) wait_cnt[i] = 0;
      end
    end
    check("sb drained", 64'(exp_q.size()), 64'(0));

    // ---------------- final report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
